// File: rtl/result_pkg.sv
// rtl/result_pkg.sv - shared widths and FSM state for the result serializer
package result_pkg;
  localparam int WORD_W = 40;
  localparam int BYTE_W = 8;
  localparam int NBYTES = 5;
  localparam int IDX_W  = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + (AW+1)'(1);
      else if (!do_push && do_pop) level_q <= level_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - buffers 40-bit result words and streams them out
// MSB byte first over a valid/ready byte interface.
module result_serializer
  import result_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_en,
  output logic [BYTE_W-1:0]      out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            word_count,
  output logic                   overflow,
  input  logic                   clr_ovf
);
  logic [1:0]        rst_sync_q;
  logic              rst_n_int;
  state_t            state_q;
  logic [WORD_W-1:0] shift_q;
  logic [IDX_W-1:0]  idx_q;
  logic [15:0]       word_count_q;
  logic              ovf_q;
  logic              out_valid_q;

  logic [WORD_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              xfer_d;
  logic              last_xfer_d;
  logic              pop_d;
  logic              push_d;
  logic              drop_d;

  // Assert asynchronously, release two edges after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  assign xfer_d      = out_valid_q && out_ready;
  assign last_xfer_d = xfer_d && (idx_q == LAST_IDX);
  assign pop_d       = !fifo_empty && ((state_q == IDLE) || last_xfer_d);
  assign push_d      = in_en && (!fifo_full || pop_d);
  assign drop_d      = in_en && fifo_full && !pop_d;

  sync_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n_int),
    .push (push_d),
    .pop  (pop_d),
    .din  (in_data),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(level)
  );

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      word_count_q <= '0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      // A fresh drop wins over a clear on the same edge.
      if (drop_d)       ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pop_d) begin
            shift_q     <= fifo_head;
            idx_q       <= '0;
            state_q     <= SEND;
            out_valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (last_xfer_d) begin
            word_count_q <= word_count_q + 16'd1;
            idx_q        <= '0;
            if (pop_d) begin
              shift_q <= fifo_head;
            end else begin
              shift_q     <= '0;
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end else if (xfer_d) begin
            shift_q <= {shift_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
            idx_q   <= idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_byte   = shift_q[WORD_W-1 -: BYTE_W];
  assign out_valid  = out_valid_q;
  assign word_count = word_count_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - scoreboard bench for result_serializer
module tb_result_serializer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] in_data = '0;
  logic        in_en = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  level;
  logic [15:0] word_count;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_q[$];
  string       chk_name[$];
  logic [63:0] chk_act[$];
  logic [63:0] chk_exp[$];

  logic       stall_pend = 1'b0;
  logic [7:0] stall_byte = '0;

  result_serializer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_en     (in_en),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .word_count(word_count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  // Monitor: the only process that steps the counters.
  always @(negedge clk) begin
    logic [7:0] e;
    while (chk_name.size() > 0) begin
      string       n;
      logic [63:0] a;
      logic [63:0] x;
      n = chk_name.pop_front();
      a = chk_act.pop_front();
      x = chk_exp.pop_front();
      tests++;
      if (a !== x) begin
        fails++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, x);
      end
    end
    if (stall_pend && rst) begin
      tests++;
      if (!out_valid || out_byte !== stall_byte) begin
        fails++;
        $display("FAIL stall_hold: got valid=%0b byte=0x%02h, expected valid=1 byte=0x%02h",
                 out_valid, out_byte, stall_byte);
      end
    end
    stall_pend = 1'b0;
    if (out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_byte: got 0x%02h, expected no transfer", out_byte);
      end else begin
        e = exp_q.pop_front();
        if (out_byte !== e) begin
          fails++;
          $display("FAIL byte: got 0x%02h, expected 0x%02h", out_byte, e);
        end
      end
    end else if (out_valid && !out_ready) begin
      stall_pend = 1'b1;
      stall_byte = out_byte;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_name.push_back(name);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  task automatic expect_word(input logic [39:0] w);
    for (int k = 0; k < 5; k++) exp_q.push_back(w[39-8*k -: 8]);
  endtask

  function automatic logic [39:0] ovw(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, 8'hA5, b ^ 8'h3C, 8'h5A, ~b};
  endfunction

  task automatic push_word(input logic [39:0] w, input bit expected);
    in_en = 1'b1;
    in_data = w;
    if (expected) expect_word(w);
    tick();
    in_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 2000 && (exp_q.size() != 0 || out_valid); i++) tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_en = 1'b0;
    clr_ovf = 1'b0;
    out_ready = 1'b1;
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_byte", 64'(out_byte), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_wcount", 64'(word_count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int cnt;
    int seen;

    // Single word, latency and order
    do_reset();
    push_word(40'h0123456789, 1'b1);
    check("lat_before", 64'(out_valid), 64'd0);
    check("lat_level", 64'(level), 64'd1);
    tick();
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_first", 64'(out_byte), 64'h01);
    wait_drain("single_drain");
    check("single_wcount", 64'(word_count), 64'd1);
    check("single_idle", 64'(out_valid), 64'd0);

    // Backpressure, ready toggles starting low
    do_reset();
    out_ready = 1'b0;
    push_word(40'h0123456789, 1'b1);
    tick();
    cnt = 0;
    for (int i = 0; i < 40 && out_valid; i++) begin
      out_ready = i[0];
      cnt++;
      tick();
    end
    check("bp_send_cycles", 64'(cnt), 64'd10);
    out_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_wcount", 64'(word_count), 64'd1);

    // Back-to-back words
    do_reset();
    expect_word(40'h1122334455);
    expect_word(40'h66778899AA);
    expect_word(40'hBBCCDDEEFF);
    in_en = 1'b1;
    in_data = 40'h1122334455;
    tick();
    in_data = 40'h66778899AA;
    tick();
    cnt = 0;
    in_data = 40'hBBCCDDEEFF;
    if (out_valid) cnt++;
    tick();
    in_en = 1'b0;
    for (int i = 0; i < 40 && out_valid; i++) begin
      cnt++;
      tick();
    end
    check("b2b_contig", 64'(cnt), 64'd15);
    wait_drain("b2b_drain");
    check("b2b_wcount", 64'(word_count), 64'd3);

    // Overflow, clear priority, drain order
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) push_word(ovw(i), i <= DEPTH);
    check("ovf_level", 64'(level), 64'(DEPTH));
    check("ovf_set", 64'(overflow), 64'd1);
    clr_ovf = 1'b1;
    push_word(ovw(99), 1'b0);
    clr_ovf = 1'b0;
    check("ovf_clr_vs_drop", 64'(overflow), 64'd1);
    check("ovf_level_hold", 64'(level), 64'(DEPTH));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_wcount", 64'(word_count), 64'(DEPTH + 1));
    check("ovf_level_end", 64'(level), 64'd0);

    // Full FIFO with push on the last-byte pop edge
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_word(ovw(i + 40), 1'b1);
    check("full_level", 64'(level), 64'(DEPTH));
    out_ready = 1'b1;
    repeat (4) tick();
    push_word(40'hC0FFEE1234, 1'b1);
    check("full_pp_ovf", 64'(overflow), 64'd0);
    check("full_pp_level", 64'(level), 64'(DEPTH));
    wait_drain("full_pp_drain");
    check("full_pp_wcount", 64'(word_count), 64'(DEPTH + 2));

    // Reset after byte 2 of a word
    do_reset();
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC);
    push_word(40'hAABBCCDDEE, 1'b0);
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_wcount", 64'(word_count), 64'd0);
    check("mid_rst_byte", 64'(out_byte), 64'd0);
    check("mid_rst_q_empty", 64'(exp_q.size()), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mid_rst_silent", 64'(seen), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter: DEPTH, 16, FIFO capacity in 40-bit words (power of two, 2..256).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_data  in  40  processor result word.
REQ-005 SHALL have port: in_en  in  1  processor enable; word valid this cycle; no backpressure to source.
REQ-006 SHALL have port: out_byte  out  8  serialized byte.
REQ-007 SHALL have port: out_valid  out  1  out_byte valid.
REQ-008 SHALL have port: out_ready  in  1  sink accepts byte.
REQ-009 SHALL have port: level  out  $clog2(DEPTH)+1  words held in FIFO, excluding the word being sent.
REQ-010 SHALL have port: word_count  out  16  words fully transmitted.
REQ-011 SHALL have port: overflow  out  1  sticky; a word was dropped.
REQ-012 SHALL have port: clr_ovf  in  1  synchronous clear of overflow.

Function
REQ-013 SHALL write in_data into FIFO on a rising edge with in_en=1 when level<DEPTH, or when level==DEPTH and a pop occurs on the same edge.
REQ-014 SHALL drop the word and set overflow when in_en=1, level==DEPTH and no pop occurs on that edge; FIFO contents unchanged.
REQ-015 SHALL give clr_ovf priority below a new overflow on the same edge, leaving overflow set.
REQ-016 SHALL implement FSM with states IDLE and SEND; reset state IDLE.
REQ-017 IDLE: when level>0, pop head into 40-bit shift register, byte index=0, go to SEND on the same edge.
REQ-018 SEND: out_valid=1; out_byte=shift[39:32]; byte transfers on edges with out_valid&&out_ready.
REQ-019 SHALL send the word MSB first: bytes [39:32],[31:24],[23:16],[15:8],[7:0]; index 0..4.
REQ-020 SHALL hold out_byte and out_valid stable while out_ready=0.
REQ-021 On transfer of byte index 4: increment word_count (wrap 0xFFFF->0x0000); if level>0, pop next word and stay in SEND with no bubble cycle, else go to IDLE.
REQ-022 Latency: word written on edge N into an empty FIFO with FSM in IDLE SHALL give out_valid=1 after edge N+1.
REQ-023 out_valid SHALL be 0 in IDLE.
REQ-024 A push and a pop on the same edge SHALL leave level unchanged.

Reset
REQ-025 rst=0 SHALL immediately force: state IDLE, FIFO empty, level=0, out_valid=0, out_byte=0, word_count=0, overflow=0, shift register=0, byte index=0.
REQ-026 Reset during SEND SHALL discard the partial word; no further bytes are output after reset release until a new word is written.
REQ-027 Reset release SHALL be synchronized internally to clk; behaviour is defined from the first edge after release.

Structure
REQ-028 Package result_pkg SHALL hold WORD_W=40, BYTE_W=8, NBYTES=5 and the FSM state enum.
REQ-029 FIFO SHALL be a separate sub-module sync_fifo with push, pop, full, empty and level ports; serializer FSM SHALL be in result_serializer.

Verification
REQ-030 Single word: in_en=1 for one cycle with 0x0123456789, out_ready=1 -> bytes 01,23,45,67,89 on 5 consecutive cycles; word_count=1; then IDLE.
REQ-031 Backpressure: as REQ-030 with out_ready toggled 1/0 every cycle -> same byte order; out_byte stable during stalls; 10 cycles of SEND.
REQ-032 Back-to-back: 3 words pushed on consecutive cycles, out_ready=1 -> 15 contiguous out_valid cycles; word_count=3.
REQ-033 Overflow: out_ready=0, push DEPTH+2 words -> level=DEPTH, overflow=1, last word dropped; clr_ovf=1 -> overflow=0; drain yields the first DEPTH+1 words (one in shift register plus DEPTH in FIFO) in order.
REQ-034 Full with simultaneous push and pop: FIFO full, byte index 4 transfers while in_en=1 -> word accepted, overflow stays 0, level stays DEPTH.
REQ-035 Reset mid-word: assert rst after byte 2 of 0xAABBCCDDEE -> out_valid=0 immediately; no further bytes; word_count=0.
